data_demux4_buf: RTL and testbench
==================================

DATA_DEMUX4_BUF -- requirements
Module: data_demux4_buf

Interface
REQ-001 The block SHALL take parameter DATA_BUS_WIDTH, default 16 from params.v, as the width of every data port.
REQ-002 The block SHALL take parameter COUNT_WIDTH, default 16, as the width of the accepted-word counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  source offers a word.
REQ-006 in_select  input  2  destination port index, 0..3.
REQ-007 in_data  input  DATA_BUS_WIDTH  word to route.
REQ-008 in_ready  output  1  block accepts the offered word this cycle.
REQ-009 out_valid  output  4  bit k: port k holds a word.
REQ-010 out_ready  input  4  bit k: consumer k takes the word this cycle.
REQ-011 out_data0..out_data3  output  DATA_BUS_WIDTH each  held word of port 0..3.
REQ-012 accept_count  output  COUNT_WIDTH  total words accepted since reset.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer on port k SHALL occur where out_valid[k] and out_ready[k] are both 1.
REQ-014 Each port SHALL hold a one-entry buffer with states EMPTY and FULL; out_valid[k] is 1 exactly when port k is FULL.
REQ-015 in_ready SHALL be combinational: 1 when port in_select is EMPTY, or FULL with out_ready[in_select] = 1; it SHALL NOT depend on in_valid.
REQ-016 Transitions per port k: EMPTY -> FULL on input transfer to k; FULL -> EMPTY on output transfer with no input transfer to k; FULL -> FULL, replacing the data, on simultaneous output and input transfer to k.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears on out_data[in_select] with out_valid set from edge N.
REQ-018 out_data[k] SHALL remain stable while out_valid[k] = 1 and out_ready[k] = 0.
REQ-019 Ports SHALL be independent: a FULL, stalled port SHALL NOT block input transfers to other ports.
REQ-020 At most one port SHALL be written per cycle; ports not selected keep their state apart from their own output transfers.
REQ-021 Words to the same port SHALL be delivered in acceptance order; no word is dropped or duplicated.
REQ-022 accept_count SHALL increment by 1 on every input transfer and wrap from all-ones to 0.
REQ-023 in_select and in_data SHALL be ignored when in_valid = 0.

Reset
REQ-024 With reset_n = 0 at a rising edge, all ports SHALL go EMPTY, out_valid = 4'b0000, out_data0..3 = 0, accept_count = 0, regardless of in-flight transfers.
REQ-025 While reset_n = 0, in_ready SHALL be 0.
REQ-026 Words buffered when reset asserts SHALL be discarded; the first transfer after release SHALL be accepted on the first edge with reset_n = 1.

Structure
REQ-027 DATA_BUS_WIDTH SHALL come from the shared params.v include; no local redefinition.
REQ-028 The per-port buffer SHALL be one sub-module, demux_slot (load, take, data in, valid/data out), instantiated four times.
REQ-029 Select decode, in_ready and the counter SHALL reside in data_demux4_buf.

Verification
REQ-030 Reset, then in_select=2, in_data=0x1234, in_valid=1 for one cycle, out_ready=4'b0000 -> next cycle out_valid=4'b0100, out_data2=0x1234, accept_count=1.
REQ-031 Port 1 FULL with 0xAAAA, out_ready[1]=0, offer 0xBBBB to port 1 -> in_ready=0; raise out_ready[1] -> same edge 0xAAAA taken, 0xBBBB loaded, out_valid[1] stays 1, out_data1=0xBBBB.
REQ-032 Port 0 FULL and stalled, offer 0x0003 to port 3 -> in_ready=1, next cycle out_valid=4'b1001, out_data0 unchanged.
REQ-033 accept_count preset to 0xFFFF via 65535 transfers, one more transfer -> accept_count=0x0000.
REQ-034 All four ports FULL, reset_n=0 for one edge -> out_valid=4'b0000, all out_data=0, accept_count=0, in_ready=0 during reset, 1 next cycle with port EMPTY.
REQ-035 Random in_valid/out_ready over 10000 cycles with scoreboard -> per-port order preserved, no loss, no duplication, accept_count equals transfers mod 2^16.

Source files
------------

// File: rtl/data_demux4_buf_pkg.sv
// Shared parameters and types for the 1-to-4 buffered data demultiplexer.
// This package is the single shared source of the data-bus width; no module redefines it.
package data_demux4_buf_pkg;

    localparam int DEF_DATA_BUS_WIDTH = 16;
    localparam int DEF_COUNT_WIDTH    = 16;
    localparam int NUM_PORTS          = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/data_demux4_buf_slot.sv
// demux_slot: one-entry output buffer (EMPTY/FULL) for one demux port.
// Handshake: i_load is a granted input transfer, i_take a granted output transfer.
module demux_slot
    import data_demux4_buf_pkg::*;
#(
    parameter int W = DEF_DATA_BUS_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_take,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    slot_state_t  r_state;
    logic [W-1:0] r_data;

    // A load wins over a take: simultaneous take+load keeps the slot FULL with the new word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
        end else if (i_take) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule

// File: rtl/data_demux4_buf.sv
// data_demux4_buf: routes each accepted word to one of four one-entry port buffers.
// valid/ready: a transfer happens on an edge where both are 1; in_ready never looks at in_valid.
module data_demux4_buf
    import data_demux4_buf_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [1:0]                in_select,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic [3:0]                out_valid,
    input  logic [3:0]                out_ready,
    output logic [DATA_BUS_WIDTH-1:0] out_data0,
    output logic [DATA_BUS_WIDTH-1:0] out_data1,
    output logic [DATA_BUS_WIDTH-1:0] out_data2,
    output logic [DATA_BUS_WIDTH-1:0] out_data3,
    output logic [COUNT_WIDTH-1:0]    accept_count
);

    logic [NUM_PORTS-1:0]      w_valid;
    logic [NUM_PORTS-1:0]      w_load;
    logic [NUM_PORTS-1:0]      w_take;
    logic [DATA_BUS_WIDTH-1:0] w_data [NUM_PORTS];
    logic                      w_accept;
    logic [COUNT_WIDTH-1:0]    r_count;

    // The selected port can accept when empty, or when it is draining on this same edge.
    assign in_ready = reset_n && (!w_valid[in_select] || out_ready[in_select]);
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        assign w_load[k] = w_accept && (in_select == 2'(k));
        assign w_take[k] = w_valid[k] && out_ready[k];

        demux_slot #(
            .W(DATA_BUS_WIDTH)
        ) u_slot (
            .clk    (clk),
            .reset_n(reset_n),
            .i_load (w_load[k]),
            .i_take (w_take[k]),
            .i_data (in_data),
            .o_valid(w_valid[k]),
            .o_data (w_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign out_valid    = w_valid;
    assign out_data0    = w_data[0];
    assign out_data1    = w_data[1];
    assign out_data2    = w_data[2];
    assign out_data3    = w_data[3];
    assign accept_count = r_count;

endmodule

// File: tb/tb_data_demux4_buf.sv
// Bench for data_demux4_buf: per-port queue model checked every cycle, plus directed literal checks.
module tb_data_demux4_buf;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [1:0]    in_select;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [CW-1:0] accept_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [W-1:0]  exp_q [4][$];
    logic [CW-1:0] m_cnt = '0;

    data_demux4_buf #(.DATA_BUS_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_select(in_select),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .accept_count(accept_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] dut_data(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic model_ready();
        return reset_n && (exp_q[in_select].size() == 0 || out_ready[in_select]);
    endfunction

    // Model: each port is a queue of accepted words; the head is what the port must show.
    always @(posedge clk) begin : model
        logic acc;
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            m_cnt = '0;
        end else begin
            acc = in_valid && model_ready();
            for (int k = 0; k < 4; k++)
                if (exp_q[k].size() > 0 && out_ready[k]) void'(exp_q[k].pop_front());
            if (acc) begin
                exp_q[in_select].push_back(in_data);
                m_cnt = m_cnt + 1'b1;
            end
            for (int k = 0; k < 4; k++)
                if (exp_q[k].size() > 1) chk("model_depth", exp_q[k].size(), 1);
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] ev;
        if (chk_en) begin
            for (int k = 0; k < 4; k++) ev[k] = (exp_q[k].size() > 0);
            chk("cyc_out_valid", out_valid, ev);
            chk("cyc_in_ready", in_ready, model_ready());
            chk("cyc_accept_count", accept_count, m_cnt);
            for (int k = 0; k < 4; k++)
                if (exp_q[k].size() > 0) chk("cyc_out_data", dut_data(k), exp_q[k][0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'b0000);
        @(posedge clk);
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_count", accept_count, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_data0", out_data0, 16'h0000);
        chk("rst_data3", out_data3, 16'h0000);

        // Single word to port 2.
        reset_n = 1'b1;
        drive(1'b1, 2'd2, 16'h1234, 4'b0000);
        #1 chk("p2_in_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk("p2_out_valid", out_valid, 4'b0100);
        chk("p2_out_data2", out_data2, 16'h1234);
        chk("p2_count", accept_count, 16'd1);

        // Stalled port 1 blocks its own next word until the consumer takes.
        drive(1'b1, 2'd1, 16'hAAAA, 4'b0000);
        step();
        drive(1'b1, 2'd1, 16'hBBBB, 4'b0000);
        #1 chk("p1_stall_ready", in_ready, 1'b0);
        step();
        chk("p1_stall_data", out_data1, 16'hAAAA);
        out_ready = 4'b0010;
        #1 chk("p1_pass_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk("p1_out_valid", out_valid[1], 1'b1);
        chk("p1_out_data1", out_data1, 16'hBBBB);
        chk("p1_count", accept_count, 16'd3);

        // Drain, then a stalled port 0 must not block port 3.
        drive(1'b0, 2'd0, '0, 4'b0110);
        step();
        chk("drain_out_valid", out_valid, 4'b0000);
        drive(1'b1, 2'd0, 16'h5555, 4'b0000);
        step();
        drive(1'b1, 2'd3, 16'h0003, 4'b0000);
        #1 chk("p3_in_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk("p3_out_valid", out_valid, 4'b1001);
        chk("p3_out_data0", out_data0, 16'h5555);
        chk("p3_out_data3", out_data3, 16'h0003);
        chk("p3_count", accept_count, 16'd5);

        // All four full, then reset with a word in flight.
        drive(1'b1, 2'd1, 16'h1111, 4'b0000);
        step();
        drive(1'b1, 2'd2, 16'h2222, 4'b0000);
        step();
        chk("full_out_valid", out_valid, 4'b1111);
        reset_n = 1'b0;
        drive(1'b1, 2'd0, 16'h9999, 4'b1111);
        #1 chk("rst2_in_ready", in_ready, 1'b0);
        step();
        chk("rst2_out_valid", out_valid, 4'b0000);
        chk("rst2_data1", out_data1, 16'h0000);
        chk("rst2_data2", out_data2, 16'h0000);
        chk("rst2_count", accept_count, 16'h0000);
        chk("rst2_in_ready_hold", in_ready, 1'b0);
        reset_n = 1'b1;
        drive(1'b1, 2'd0, 16'h00AB, 4'b0000);
        #1 chk("post_rst_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk("post_rst_valid", out_valid, 4'b0001);
        chk("post_rst_data0", out_data0, 16'h00AB);
        chk("post_rst_count", accept_count, 16'd1);

        // Counter wrap: 65535 transfers from zero, then one more.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 2'(i % 4), W'($urandom_range(0, 65535)), 4'b1111);
            step();
        end
        chk("wrap_ffff", accept_count, 16'hFFFF);
        step();
        chk("wrap_zero", accept_count, 16'h0000);

        // Random traffic; the per-cycle compare and model carry the checking.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  W'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            step();
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
        step();
        chk("end_drained", out_valid, 4'b0000);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
